// File: rtl/gremlin_hit_detector.sv
// -----------------------------------------------------------------------------
// gremlin_hit_detector
//
// Purpose:
//   Once per video frame, on the rising edge of vsync_in, the block takes a
//   snapshot of the car position and two gremlin descriptors. It then tests
//   the car bounding box against each gremlin bounding box, one gremlin per
//   cycle. Newly hit gremlins are reported, get a kill request, and add to a
//   saturating score.
//
// Ports:
//   pclk       in   1   pixel clock; all state changes on its rising edge
//   rst_n      in   1   asynchronous active-low reset
//   vsync_in   in   1   frame sync; a rising edge starts one evaluation
//   grem0_in   in  24   gremlin 0: [23] color, [22:12] x, [11:1] y, [0] active
//   grem1_in   in  24   gremlin 1, same layout
//   car_x      in  11   car top-left x
//   car_y      in  11   car top-left y
//   kill_ack   in   2   per-gremlin acknowledge of kill_req
//   hit_pulse  out  1   one-cycle strobe when a frame produced at least one hit
//   hit_mask   out  2   gremlins hit in the last completed evaluation
//   kill_req   out  2   per-gremlin deactivate request, held until acknowledged
//   score      out 10   hits counted since reset, saturating at SCORE_MAX
//   busy       out  1   high while an evaluation is in progress
//
// Timing: with the vsync edge seen in cycle N, the FSM is in SNAP in N+1,
// CHK0 in N+2, CHK1 in N+3 and DONE in N+4. The registered results are visible
// from N+5.
// -----------------------------------------------------------------------------
module gremlin_hit_detector #(
    parameter int unsigned CAR_W     = 32,
    parameter int unsigned CAR_H     = 32,
    parameter int unsigned GREM_W    = 16,
    parameter int unsigned GREM_H    = 32,
    parameter int unsigned SCORE_MAX = 999
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vsync_in,
    input  logic [23:0] grem0_in,
    input  logic [23:0] grem1_in,
    input  logic [10:0] car_x,
    input  logic [10:0] car_y,
    input  logic [1:0]  kill_ack,
    output logic        hit_pulse,
    output logic [1:0]  hit_mask,
    output logic [1:0]  kill_req,
    output logic [9:0]  score,
    output logic        busy
);

    localparam int unsigned COORD_W   = 11;
    localparam int unsigned SUM_W     = 12;
    localparam int unsigned SCORE_W   = 10;
    localparam int unsigned SCORE_SW  = SCORE_W + 1;
    localparam int unsigned NUM_GREM  = 2;

    // Gremlin descriptor layout as delivered by the sprite engine
    typedef struct packed {
        logic               color;
        logic [COORD_W-1:0] xpos;
        logic [COORD_W-1:0] ypos;
        logic               active;
    } grem_t;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        CHK0,
        CHK1,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;

    logic                 vsync_q;
    logic                 vsync_rise;

    grem_t                snap0;
    grem_t                snap1;
    logic [COORD_W-1:0]   snap_cx;
    logic [COORD_W-1:0]   snap_cy;

    logic [NUM_GREM-1:0]  pending;
    logic [NUM_GREM-1:0]  hit_c;
    logic [1:0]           hit_count;
    logic [SCORE_SW-1:0]  score_sum;
    logic [SCORE_W-1:0]   score_next;

    // The color bit has no bearing on hit detection
    logic                 unused_color;
    assign unused_color = snap0.color ^ snap1.color;

    // Axis-aligned box overlap, evaluated at 12 bits so the sums never wrap
    function automatic logic overlap(input grem_t              g,
                                     input logic [COORD_W-1:0] cx,
                                     input logic [COORD_W-1:0] cy);
        logic [SUM_W-1:0] gx;
        logic [SUM_W-1:0] gy;
        logic [SUM_W-1:0] x0;
        logic [SUM_W-1:0] y0;
        gx = SUM_W'(g.xpos);
        gy = SUM_W'(g.ypos);
        x0 = SUM_W'(cx);
        y0 = SUM_W'(cy);
        return (x0 < gx + SUM_W'(GREM_W)) && (gx < x0 + SUM_W'(CAR_W)) &&
               (y0 < gy + SUM_W'(GREM_H)) && (gy < y0 + SUM_W'(CAR_H));
    endfunction

    assign vsync_rise = vsync_in & ~vsync_q;

    // A gremlin with an outstanding kill request cannot be hit again
    always_comb begin
        hit_c    = '0;
        hit_c[0] = overlap(snap0, snap_cx, snap_cy) & snap0.active & ~kill_req[0];
        hit_c[1] = overlap(snap1, snap_cx, snap_cy) & snap1.active & ~kill_req[1];
    end

    // Saturating score update from the completed pending mask
    always_comb begin
        hit_count  = 2'({1'b0, pending[0]}) + 2'({1'b0, pending[1]});
        score_sum  = SCORE_SW'(score) + SCORE_SW'(hit_count);
        score_next = SCORE_W'(score_sum);
        if (score_sum > SCORE_SW'(SCORE_MAX)) begin
            score_next = SCORE_W'(SCORE_MAX);
        end
    end

    // FSM state register
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state; edges outside IDLE are simply not looked at
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (vsync_rise) state_next = SNAP;
            SNAP:    state_next = CHK0;
            CHK0:    state_next = CHK1;
            CHK1:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // vsync history resets high so a level already high at release is no edge
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync_in;
        end
    end

    // Frame snapshot; the checks only ever look at these copies
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            snap0   <= '0;
            snap1   <= '0;
            snap_cx <= '0;
            snap_cy <= '0;
        end else if (state == SNAP) begin
            snap0   <= grem_t'(grem0_in);
            snap1   <= grem_t'(grem1_in);
            snap_cx <= car_x;
            snap_cy <= car_y;
        end
    end

    // One gremlin is checked per cycle
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (state == CHK0) pending[0] <= hit_c[0];
            if (state == CHK1) pending[1] <= hit_c[1];
        end
    end

    // Result publication, score and strobe
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hit_pulse <= 1'b0;
            hit_mask  <= '0;
            score     <= '0;
        end else begin
            hit_pulse <= 1'b0;
            if (state == DONE) begin
                hit_mask  <= pending;
                hit_pulse <= |pending;
                score     <= score_next;
            end
        end
    end

    // Kill requests: a new hit takes priority over a same-cycle acknowledge
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            kill_req <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_GREM); i++) begin
                if (state == DONE && pending[i]) begin
                    kill_req[i] <= 1'b1;
                end else if (kill_ack[i]) begin
                    kill_req[i] <= 1'b0;
                end
            end
        end
    end

    // busy follows the state being entered so it is aligned with SNAP..DONE
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_gremlin_hit_detector.sv
module tb_gremlin_hit_detector;

    localparam int CAR_W     = 32;
    localparam int CAR_H     = 32;
    localparam int GREM_W    = 16;
    localparam int GREM_H    = 32;
    localparam int SCORE_MAX = 999;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic        vsync_in;
    logic [23:0] grem0_in;
    logic [23:0] grem1_in;
    logic [10:0] car_x;
    logic [10:0] car_y;
    logic [1:0]  kill_ack;
    logic        hit_pulse;
    logic [1:0]  hit_mask;
    logic [1:0]  kill_req;
    logic [9:0]  score;
    logic        busy;

    gremlin_hit_detector #(
        .CAR_W(CAR_W), .CAR_H(CAR_H), .GREM_W(GREM_W), .GREM_H(GREM_H),
        .SCORE_MAX(SCORE_MAX)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync_in(vsync_in),
        .grem0_in(grem0_in), .grem1_in(grem1_in),
        .car_x(car_x), .car_y(car_y), .kill_ack(kill_ack),
        .hit_pulse(hit_pulse), .hit_mask(hit_mask), .kill_req(kill_req),
        .score(score), .busy(busy)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    typedef struct {
        int mask;
        int pulse;
        int score;
        int kreq;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   passes = 0;

    // Reference state: score and outstanding kill requests
    int   m_score = 0;
    int   m_kreq  = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic bit boxes_touch(input int gx, input int gy, input int cx, input int cy);
        int gl, gr, gt, gb, cl, cr, ct, cb;
        gl = gx; gr = gx + GREM_W; gt = gy; gb = gy + GREM_H;
        cl = cx; cr = cx + CAR_W;  ct = cy; cb = cy + CAR_H;
        return (cl < gr) && (gl < cr) && (ct < gb) && (gt < cb);
    endfunction

    function automatic int clamp11(input int v);
        if (v < 0) return 0;
        if (v > 2047) return 2047;
        return v;
    endfunction

    // Monitor: results appear when busy falls; hit_pulse must be low otherwise
    logic prev_busy = 1'b0;
    always @(negedge pclk) begin
        exp_t e;
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (expq.size() == 0) begin
                    check("unexpected_evaluation", 1, 0);
                end else begin
                    e = expq.pop_front();
                    check("result_cycle", cyc, e.cyc);
                    check("hit_pulse", int'(hit_pulse), e.pulse);
                    check("hit_mask", int'(hit_mask), e.mask);
                    check("score", int'(score), e.score);
                    check("kill_req", int'(kill_req), e.kreq);
                end
            end else begin
                check("hit_pulse_quiet", int'(hit_pulse), 0);
            end
            prev_busy = busy;
        end
    end

    // One frame: program inputs, raise vsync, queue the expected outcome
    task automatic run_frame(input int gx0, input int gy0, input bit a0,
                             input int gx1, input int gy1, input bit a1,
                             input int cx, input int cy, input int ack_after,
                             input bit ack_during, input bit dbl_edge);
        exp_t e;
        int   m;
        int   kr;
        int   k;
        vsync_in = 1'b0;
        tick();
        grem0_in = {1'($urandom), 11'(gx0), 11'(gy0), a0};
        grem1_in = {1'($urandom), 11'(gx1), 11'(gy1), a1};
        car_x    = 11'(cx);
        car_y    = 11'(cy);
        // an acknowledge held from the edge clears old requests before the checks
        kr = ack_during ? 0 : m_kreq;
        m  = 0;
        if (a0 && boxes_touch(gx0, gy0, cx, cy) && !kr[0]) m |= 1;
        if (a1 && boxes_touch(gx1, gy1, cx, cy) && !kr[1]) m |= 2;
        m_score = m_score + (m & 1) + ((m >> 1) & 1);
        if (m_score > SCORE_MAX) m_score = SCORE_MAX;
        m_kreq  = kr | m;
        vsync_in = 1'b1;
        if (ack_during) kill_ack = 2'b11;
        k = cyc;
        e.mask = m; e.pulse = (m != 0); e.score = m_score; e.kreq = m_kreq; e.cyc = k + 5;
        expq.push_back(e);
        tick();
        check("busy_in_snap", int'(busy), 1);
        vsync_in = 1'b0;
        tick();
        // snapshot is already taken: scramble the live inputs
        grem0_in = 24'($urandom);
        grem1_in = 24'($urandom);
        car_x    = 11'($urandom);
        car_y    = 11'($urandom);
        if (dbl_edge) vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
        tick();
        kill_ack = 2'b00;
        for (int i = 0; i < 20 && busy; i++) tick();
        if (busy) check("busy_timeout", 1, 0);
        if (ack_after != 0) begin
            kill_ack = 2'(ack_after);
            tick();
            kill_ack = 2'b00;
            m_kreq = m_kreq & ~ack_after;
        end
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hit_pulse"}, int'(hit_pulse), 0);
        check({tag, "_hit_mask"},  int'(hit_mask), 0);
        check({tag, "_kill_req"},  int'(kill_req), 0);
        check({tag, "_score"},     int'(score), 0);
        check({tag, "_busy"},      int'(busy), 0);
    endtask

    initial begin
        int cx, cy;
        rst_n    = 1'b0;
        vsync_in = 1'b1;
        grem0_in = '0;
        grem1_in = '0;
        car_x    = '0;
        car_y    = '0;
        kill_ack = '0;
        #1;
        check_reset_state("reset");
        tick();
        tick();
        rst_n = 1'b1;
        // vsync high across release must not start an evaluation
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_eval_vsync_high", int'(busy), 0);
        end

        // Basic hit on gremlin 0 only
        run_frame(110, 120, 1, 110, 120, 0, 100, 100, 0, 0, 0);
        run_frame(0, 0, 0, 0, 0, 0, 100, 100, 1, 0, 0);

        // Box edges on both axes, both sides
        run_frame(132, 100, 1, 0, 0, 0, 100, 100, 0, 0, 0);
        run_frame(131, 100, 1, 0, 0, 0, 100, 100, 1, 0, 0);
        run_frame(100, 132, 1, 0, 0, 0, 100, 100, 0, 0, 0);
        run_frame(100, 131, 1, 0, 0, 0, 100, 100, 1, 0, 0);
        run_frame(84, 100, 1, 0, 0, 0, 100, 100, 0, 0, 0);
        run_frame(85, 100, 1, 0, 0, 0, 100, 100, 1, 0, 0);
        run_frame(100, 68, 1, 0, 0, 0, 100, 100, 0, 0, 0);
        run_frame(100, 69, 1, 0, 0, 0, 100, 100, 1, 0, 0);

        // Both hit, no re-hit while requests pending, hits again after ack
        run_frame(110, 110, 1, 120, 100, 1, 100, 100, 0, 0, 0);
        run_frame(110, 110, 1, 120, 100, 1, 100, 100, 3, 0, 0);
        run_frame(110, 110, 1, 120, 100, 1, 100, 100, 0, 0, 0);

        // Acknowledge coinciding with DONE: the new request wins
        run_frame(110, 110, 1, 120, 100, 1, 100, 100, 3, 1, 0);

        // Second edge two cycles later is dropped
        run_frame(110, 110, 1, 500, 500, 1, 100, 100, 1, 0, 1);

        // Reset during CHK1 aborts the evaluation
        vsync_in = 1'b0;
        grem0_in = {1'b0, 11'd110, 11'd110, 1'b1};
        grem1_in = {1'b0, 11'd120, 11'd110, 1'b1};
        car_x = 11'd100;
        car_y = 11'd100;
        tick();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        m_score = 0;
        m_kreq  = 0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_pulse", int'(hit_pulse), 0);
            check("abort_score", int'(score), 0);
        end

        // Reset released with vsync high, then a clean frame
        vsync_in = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_eval_vsync_high2", int'(busy), 0);
        end
        run_frame(110, 120, 1, 0, 0, 0, 100, 100, 1, 0, 0);

        // Randomized frames around the car
        for (int n = 0; n < 200; n++) begin
            cx = int'($urandom_range(0, 2000));
            cy = int'($urandom_range(0, 2000));
            run_frame(clamp11(cx + int'($urandom_range(0, 90)) - 40),
                      clamp11(cy + int'($urandom_range(0, 110)) - 50),
                      1'($urandom),
                      clamp11(cx + int'($urandom_range(0, 90)) - 40),
                      clamp11(cy + int'($urandom_range(0, 110)) - 50),
                      1'($urandom),
                      cx, cy, int'($urandom_range(0, 3)), 0, 0);
        end

        // Clear any leftover requests, then fill score up to 998
        run_frame(0, 0, 0, 0, 0, 0, 1000, 1000, 3, 0, 0);
        while (m_score < 998) begin
            if (998 - m_score >= 2)
                run_frame(110, 110, 1, 120, 100, 1, 100, 100, 3, 0, 0);
            else
                run_frame(110, 110, 1, 120, 100, 0, 100, 100, 3, 0, 0);
        end
        run_frame(110, 110, 1, 120, 100, 1, 100, 100, 3, 0, 0);
        run_frame(110, 110, 1, 120, 100, 0, 100, 100, 3, 0, 0);

        for (int i = 0; i < 20 && expq.size() != 0; i++) tick();
        check("queue_drained", expq.size(), 0);
        check("final_score", int'(score), SCORE_MAX);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
